// File: rtl/seg_capture.sv
// Monitor for the dual-digit multiplexed common-anode 7-segment bus: samples, debounces and decodes
// each digit back to hex. Define SEG_CAPTURE_ERRCNT_EN to add the saturating err_count output.
module seg_capture #(
    parameter int unsigned SAMPLE_DIV    = 1000,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segs_in,
    input  logic [1:0] an_in,
    input  logic       err_clr,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [1:0] valid,
    output logic       update,
`ifdef SEG_CAPTURE_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    output logic [1:0] err
);

    localparam logic [15:0] TickLast  = 16'(SAMPLE_DIV - 1);
    localparam logic [3:0]  StableMax = 4'(STABLE_CYCLES);
    localparam logic [3:0]  StablePre = 4'(STABLE_CYCLES - 1);

    logic [15:0] tick_cnt;
    logic        tick;
    logic [6:0]  p;
    logic [6:0]  cand_q [2];
    logic [3:0]  cnt_q  [2];
    logic [3:0]  digit_q [2];
    logic [1:0]  samp;
    logic [1:0]  match;
    logic [1:0]  commit;
    logic [1:0]  err_set;
    logic [3:0]  dec_val;
    logic        dec_legal;

    assign tick   = (tick_cnt == TickLast);
    assign p      = ~segs_in;
    assign digit0 = digit_q[0];
    assign digit1 = digit_q[1];

    always_comb begin
        dec_legal = 1'b1;
        dec_val   = 4'h0;
        case (p)
            7'h3F: dec_val = 4'h0;
            7'h06: dec_val = 4'h1;
            7'h5B: dec_val = 4'h2;
            7'h4F: dec_val = 4'h3;
            7'h66: dec_val = 4'h4;
            7'h6D: dec_val = 4'h5;
            7'h7D: dec_val = 4'h6;
            7'h07: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h67: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        samp[0] = tick && (an_in == 2'b10);
        samp[1] = tick && (an_in == 2'b01);
        for (int n = 0; n < 2; n++) begin
            match[n]   = (p == cand_q[n]);
            // Commit only on the S-1 -> S transition, so a saturated run never recommits.
            commit[n]  = samp[n] && match[n] && (cnt_q[n] == StablePre);
            err_set[n] = commit[n] && !dec_legal && (p != 7'h00);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            valid    <= '0;
            update   <= 1'b0;
            err      <= '0;
            for (int n = 0; n < 2; n++) begin
                cand_q[n]  <= '0;
                cnt_q[n]   <= '0;
                digit_q[n] <= '0;
            end
`ifdef SEG_CAPTURE_ERRCNT_EN
            err_count <= '0;
`endif
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 16'd1;
            // Set has priority over a coincident clear.
            err      <= (err & ~{2{err_clr}}) | err_set;
            update   <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                if (samp[n]) begin
                    if (match[n]) begin
                        if (cnt_q[n] != StableMax) cnt_q[n] <= cnt_q[n] + 4'd1;
                    end else begin
                        cand_q[n] <= p;
                        cnt_q[n]  <= 4'd1;
                    end
                end
                if (commit[n]) begin
                    if (dec_legal) begin
                        digit_q[n] <= dec_val;
                        valid[n]   <= 1'b1;
                        if ((digit_q[n] != dec_val) || !valid[n]) update <= 1'b1;
                    end else if (p == 7'h00) begin
                        valid[n] <= 1'b0;
                        if (valid[n]) update <= 1'b1;
                    end
                end
            end
`ifdef SEG_CAPTURE_ERRCNT_EN
            if (err_clr) begin
                err_count <= {7'd0, |err_set};
            end else if ((|err_set) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture: directed scenarios plus randomized traffic, all compared
// every cycle against a behavioural run-length model of the display bus.
module tb_seg_capture;

    localparam int SD = 4;
    localparam int SC = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] segs_in = 7'h7F;
    logic [1:0] an_in = 2'b11;
    logic       err_clr = 1'b0;
    logic [3:0] digit0, digit1;
    logic [1:0] valid, err;
    logic       update;
`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [7:0] err_count;
`endif

    seg_capture #(.SAMPLE_DIV(SD), .STABLE_CYCLES(SC)) dut (
        .clk      (clk),
        .reset    (reset),
        .segs_in  (segs_in),
        .an_in    (an_in),
        .err_clr  (err_clr),
        .digit0   (digit0),
        .digit1   (digit1),
        .valid    (valid),
        .update   (update),
`ifdef SEG_CAPTURE_ERRCNT_EN
        .err_count(err_count),
`endif
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int upd_cnt = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state
    int         edges;
    logic [3:0] m_dig [2];
    logic [1:0] m_valid, m_err;
    logic       m_upd;
    logic [6:0] m_last [2];
    int         m_run [2];
    int         m_ecnt;

    function automatic int lookup(input logic [6:0] pat);
        for (int i = 0; i < 16; i++) if (seg_tab[i] == pat) return i;
        return -1;
    endfunction

    task automatic model_reset();
        edges = 0;
        m_valid = 2'b00;
        m_err = 2'b00;
        m_upd = 1'b0;
        m_ecnt = 0;
        for (int n = 0; n < 2; n++) begin
            m_dig[n] = 4'h0;
            m_last[n] = 7'h00;
            m_run[n] = 0;
        end
    endtask

    task automatic model_edge();
        int n;
        int v;
        logic [6:0] pat;
        logic [1:0] ne;
        m_upd = 1'b0;
        edges++;
        ne = err_clr ? 2'b00 : m_err;
        if (err_clr) m_ecnt = 0;
        if ((edges % SD == 0) && (an_in == 2'b10 || an_in == 2'b01)) begin
            n = (an_in == 2'b10) ? 0 : 1;
            pat = ~segs_in;
            if (pat == m_last[n]) begin
                m_run[n]++;
            end else begin
                m_last[n] = pat;
                m_run[n] = 1;
            end
            if (m_run[n] == SC) begin
                v = lookup(pat);
                if (v >= 0) begin
                    if (m_dig[n] != 4'(v) || !m_valid[n]) m_upd = 1'b1;
                    m_dig[n] = 4'(v);
                    m_valid[n] = 1'b1;
                end else if (pat == 7'h00) begin
                    if (m_valid[n]) m_upd = 1'b1;
                    m_valid[n] = 1'b0;
                end else begin
                    ne[n] = 1'b1;
                    if (m_ecnt < 255) m_ecnt++;
                end
            end
        end
        m_err = ne;
    endtask

    task automatic check_model();
        n_cmp++;
        assert ({digit0, digit1, valid, update, err} ===
                {m_dig[0], m_dig[1], m_valid, m_upd, m_err})
        else begin
            n_bad++;
            $error("FAIL model t=%0t got d0=%h d1=%h v=%b u=%b e=%b exp d0=%h d1=%h v=%b u=%b e=%b",
                   $time, digit0, digit1, valid, update, err,
                   m_dig[0], m_dig[1], m_valid, m_upd, m_err);
        end
`ifdef SEG_CAPTURE_ERRCNT_EN
        n_cmp++;
        assert (err_count === 8'(m_ecnt))
        else begin
            n_bad++;
            $error("FAIL err_count t=%0t got=%h exp=%h", $time, err_count, 8'(m_ecnt));
        end
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (update === 1'b1) upd_cnt++;
        check_model();
    endtask

    task automatic ticks(input int n);
        repeat (n * SD) step();
    endtask

    function automatic logic [6:0] pick();
        int c;
        c = $urandom_range(0, 5);
        if (c == 0) return 7'h00;
        if (c == 1) return 7'($urandom_range(0, 127));
        return seg_tab[$urandom_range(0, 15)];
    endfunction

    logic [6:0] pat [2];

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {20'd0, digit0, digit1, valid, update, err}, 32'd0);
        @(negedge clk) reset = 1'b1;

        // Stable legal pattern on digit0, then hold without re-pulsing.
        an_in = 2'b10; segs_in = ~7'h5B;
        upd_cnt = 0;
        ticks(3);
        chk("commit2_digit0", 32'(digit0), 32'h2);
        chk("commit2_valid", 32'(valid), 32'b01);
        chk("commit2_update", upd_cnt, 1);
        upd_cnt = 0;
        ticks(10);
        chk("hold_no_update", upd_cnt, 0);

        // Interleaved digits.
        for (int i = 0; i < 3; i++) begin
            an_in = 2'b10; segs_in = ~7'h7C; ticks(1);
            an_in = 2'b01; segs_in = ~7'h06; ticks(1);
        end
        chk("mux_digit0", 32'(digit0), 32'hB);
        chk("mux_digit1", 32'(digit1), 32'h1);
        chk("mux_valid", 32'(valid), 32'b11);

        // Short run followed by a full run of a new pattern.
        an_in = 2'b10; segs_in = ~7'h7C;
        upd_cnt = 0;
        ticks(2);
        chk("short_run_no_update", upd_cnt, 0);
        segs_in = ~7'h79;
        ticks(3);
        chk("run_e_digit0", 32'(digit0), 32'hE);

        // Illegal pattern on digit1, set-over-clear, then clear alone.
        an_in = 2'b01; segs_in = ~7'h01;
        ticks(3);
        chk("illegal_err", 32'(err), 32'b10);
        chk("illegal_valid", 32'(valid), 32'b11);
        chk("illegal_digit1", 32'(digit1), 32'h1);
        segs_in = ~7'h03;
        ticks(2);
        repeat (SD - 1) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("set_wins_err", 32'(err), 32'b10);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clear_err", 32'(err), 32'b00);
        repeat (SD - 1) step();

        // Blank after 8, then idle anode codes.
        an_in = 2'b10; segs_in = ~7'h7F;
        ticks(3);
        chk("commit8_digit0", 32'(digit0), 32'h8);
        upd_cnt = 0;
        segs_in = 7'h7F;
        ticks(3);
        chk("blank_valid", 32'(valid), 32'b10);
        chk("blank_digit0", 32'(digit0), 32'h8);
        chk("blank_update", upd_cnt, 1);
        upd_cnt = 0;
        an_in = 2'b00; ticks(10);
        an_in = 2'b11; ticks(10);
        chk("idle_no_update", upd_cnt, 0);
        chk("idle_valid", 32'(valid), 32'b10);

        // Reset in the middle of a run.
        an_in = 2'b10; segs_in = ~7'h66;
        ticks(2);
        #2 reset = 1'b0;
        #1;
        chk("midrun_reset", {20'd0, digit0, digit1, valid, update, err}, 32'd0);
        model_reset();
        @(negedge clk) reset = 1'b1;
        ticks(2);
        chk("post_reset_no_commit", 32'(valid), 32'b00);
        ticks(1);
        chk("post_reset_digit0", 32'(digit0), 32'h4);
        chk("post_reset_valid", 32'(valid), 32'b01);

`ifdef SEG_CAPTURE_ERRCNT_EN
        an_in = 2'b10;
        for (int i = 0; i < 300; i++) begin
            segs_in = (i % 2 == 0) ? ~7'h01 : ~7'h03;
            ticks(3);
        end
        chk("err_count_sat", 32'(err_count), 32'hFF);
`endif

        // Randomized traffic against the model.
        pat[0] = 7'h3F;
        pat[1] = 7'h06;
        for (int k = 0; k < 400; k++) begin
            int r;
            int d;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                an_in = 2'b00;
            end else if (r == 1) begin
                an_in = 2'b11;
            end else begin
                d = $urandom_range(0, 1);
                if ($urandom_range(0, 3) == 0) pat[d] = pick();
                an_in = (d == 1) ? 2'b01 : 2'b10;
                segs_in = ~pat[d];
            end
            repeat (SD) begin
                err_clr = ($urandom_range(0, 15) == 0);
                step();
            end
        end
        err_clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
